// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit: PC owner plus DEPTH-entry {pc, instr} fetch queue
// with a valid/ready head and redirect flush.
module fetch_queue_unit #(
  parameter int unsigned     XLEN        = 32,
  parameter int unsigned     DEPTH       = 4,
  parameter logic [XLEN-1:0] RESET_PC    = '0,
  parameter int unsigned     IMEM_ADDR_W = 7
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         redirect_valid,
  input  logic [XLEN-1:0]              redirect_pc,
  output logic [IMEM_ADDR_W-1:0]       imem_addr,
  input  logic [31:0]                  imem_rdata,
  output logic                         out_valid,
  output logic [31:0]                  out_instr,
  output logic [XLEN-1:0]              out_pc,
  input  logic                         out_ready,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [XLEN-1:0]              fetch_pc
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [XLEN-1:0]  pc_mem_q  [DEPTH];
  logic [31:0]      ins_mem_q [DEPTH];
  logic             push_c;
  logic             pop_c;

  // Only the word-aligned part of a redirect target is meaningful.
  logic unused_redirect_lsb;
  assign unused_redirect_lsb = ^redirect_pc[1:0];

  // Handshake qualifiers; a redirect suppresses both.
  assign pop_c  = (count_q != '0) & out_ready & ~redirect_valid;
  assign push_c = ~redirect_valid & ((count_q < DEPTH_C) | pop_c);

  // Next-state for PC, pointers and occupancy.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (push_c) begin
        fetch_pc_d = fetch_pc_q + XLEN'(4);
        wr_ptr_d   = wr_ptr_q + PTR_W'(1);
      end
      if (pop_c) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
    end
  end

  // Control state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // Queue storage; cleared on reset so the head reads zero afterwards.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        pc_mem_q[i]  <= '0;
        ins_mem_q[i] <= '0;
      end
    end else if (push_c) begin
      pc_mem_q[wr_ptr_q]  <= fetch_pc_q;
      ins_mem_q[wr_ptr_q] <= imem_rdata;
    end
  end

  // Outputs come straight from registered state.
  assign imem_addr = fetch_pc_q[IMEM_ADDR_W+1:2];
  assign fetch_pc  = fetch_pc_q;
  assign count     = count_q;
  assign out_valid = (count_q != '0);
  assign out_pc    = pc_mem_q[rd_ptr_q];
  assign out_instr = ins_mem_q[rd_ptr_q];

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Bench for fetch_queue_unit: directed phases then random traffic, checked
// by a reference queue of expected {pc, instr} entries.
module tb_fetch_queue_unit;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 7;

  logic            clk = 1'b0;
  logic            reset;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic [AW-1:0]   imem_addr;
  logic [31:0]     imem_rdata;
  logic            out_valid;
  logic [31:0]     out_instr;
  logic [XLEN-1:0] out_pc;
  logic            out_ready;
  logic [2:0]      count;
  logic [XLEN-1:0] fetch_pc;

  fetch_queue_unit #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC('0), .IMEM_ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata), .out_valid(out_valid),
    .out_instr(out_instr), .out_pc(out_pc), .out_ready(out_ready),
    .count(count), .fetch_pc(fetch_pc)
  );

  always #5 clk = ~clk;

  // Instruction memory contents: low bits tag the word index.
  logic [31:0] mem [128];
  assign imem_rdata = mem[imem_addr];

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
  } entry_t;

  entry_t          exp_q[$];
  int              model_cnt;
  logic [XLEN-1:0] model_pc;
  int              checks = 0;
  int              errors = 0;
  int              pops_seen = 0;

  function automatic logic [31:0] instr_at(input logic [XLEN-1:0] pc);
    return mem[(pc >> 2) % 128];
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    model_cnt = 0;
    model_pc  = '0;
  endtask

  // One clock: update the reference with the inputs seen at the edge,
  // then apply the next inputs just after it.
  task automatic step(input logic rdy, input logic redir, input logic [XLEN-1:0] rpc);
    logic p_pop, p_push;
    @(posedge clk);
    if (reset) begin
      model_reset();
    end else if (redirect_valid) begin
      exp_q.delete();
      model_cnt = 0;
      model_pc  = redirect_pc & ~XLEN'(3);
    end else begin
      p_pop  = (model_cnt > 0) && out_ready;
      p_push = (model_cnt < int'(DEPTH)) || p_pop;
      if (p_push) begin
        exp_q.push_back('{pc: model_pc, instr: instr_at(model_pc)});
        model_pc = model_pc + 4;
      end
      model_cnt = model_cnt + int'(p_push) - int'(p_pop);
    end
    #1;
    out_ready      = rdy;
    redirect_valid = redir;
    redirect_pc    = rpc;
  endtask

  // Monitor: compare state every cycle and consume the head when it is accepted.
  always @(negedge clk) begin
    entry_t e;
    if (!reset) begin
      check("count", 64'(count), 64'(model_cnt));
      check("out_valid", 64'(out_valid), 64'(model_cnt != 0));
      check("fetch_pc", 64'(fetch_pc), 64'(model_pc));
      check("imem_addr", 64'(imem_addr), 64'((model_pc >> 2) % 128));
      if (out_valid && model_cnt != 0) begin
        // Entries in the reference beyond what has been consumed are live.
        if (exp_q.size() == 0) begin
          check("head_present", 64'(0), 64'(1));
        end else begin
          check("out_pc", 64'(out_pc), 64'(exp_q[0].pc));
          check("out_instr", 64'(out_instr), 64'(exp_q[0].instr));
          if (out_ready && !redirect_valid) begin
            e = exp_q.pop_front();
            pops_seen++;
          end
        end
      end
    end
  end

  // The reference drops its own copy of the consumed head at the edge.
  // Keep model_cnt as the authoritative count; exp_q holds only unconsumed entries.

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = {$urandom_range(0, 65535), 16'(32'h100 + i)} & 32'hFFFF_FFFF;
    reset = 1'b1; out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    model_reset();
    #1;
    check("rst_count", 64'(count), 64'(0));
    check("rst_valid", 64'(out_valid), 64'(0));
    check("rst_fetch_pc", 64'(fetch_pc), 64'(0));
    check("rst_out_pc", 64'(out_pc), 64'(0));
    check("rst_out_instr", 64'(out_instr), 64'(0));
    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b0, '0);
    reset = 1'b0;

    // Streaming with decode always ready.
    step(1'b1, 1'b0, '0);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, '0);

    // Fill/stall, then drain while pushing.
    reset = 1'b1; step(1'b0, 1'b0, '0); reset = 1'b0;
    for (int i = 0; i < 7; i++) step(1'b0, 1'b0, '0);
    check("stall_count", 64'(count), 64'(4));
    check("stall_pc", 64'(fetch_pc), 64'(16));
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, '0);

    // Redirect flush with three entries queued.
    reset = 1'b1; step(1'b0, 1'b0, '0); reset = 1'b0;
    for (int i = 0; i < 2; i++) step(1'b0, 1'b0, '0);
    step(1'b1, 1'b1, 32'h43);
    step(1'b1, 1'b0, '0);
    check("redir_count", 64'(count), 64'(0));
    check("redir_pc", 64'(fetch_pc), 64'(32'h40));
    step(1'b1, 1'b0, '0);
    check("redir_head_pc", 64'(out_pc), 64'(32'h40));
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, '0);

    // Redirect while full and stalled, then back-to-back redirects.
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, '0);
    step(1'b0, 1'b1, 32'h200);
    step(1'b0, 1'b1, 32'h37F);
    step(1'b1, 1'b1, 32'h0202);
    step(1'b1, 1'b0, '0);
    check("b2b_pc", 64'(fetch_pc), 64'(32'h200));
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, '0);

    // Asynchronous reset mid-cycle with three entries queued.
    reset = 1'b1; step(1'b0, 1'b0, '0); reset = 1'b0;
    for (int i = 0; i < 2; i++) step(1'b0, 1'b0, '0);
    step(1'b0, 1'b0, '0);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_count", 64'(count), 64'(0));
    check("mid_rst_valid", 64'(out_valid), 64'(0));
    check("mid_rst_pc", 64'(fetch_pc), 64'(0));
    check("mid_rst_addr", 64'(imem_addr), 64'(0));
    model_reset();
    step(1'b1, 1'b0, '0);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, '0);

    // Random traffic: wrap, stalls, occasional redirects including PC wrap.
    for (int i = 0; i < 400; i++) begin
      logic r, d;
      logic [XLEN-1:0] t;
      r = ($urandom_range(0, 9) < 6);
      d = ($urandom_range(0, 24) == 0);
      t = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      step(r, d, t);
    end
    step(1'b1, 1'b0, '0);
    step(1'b1, 1'b0, '0);
    check("pops_seen_nonzero", 64'(pops_seen > 100), 64'(1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
